// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access unit. It latches one access on start, runs a single
//   req/ready (+rvalid for loads) transaction, and registers the sign/zero-extended load result.
// Latency: store 2 cycles start->done, load 3 cycles; misaligned/illegal access faults in 1 cycle.
// Backpressure: holds mem_req with stable addr/be/wdata until mem_ready; waits indefinitely for mem_rvalid.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   start, is_store, funct3, addr, wdata  access request, all latched when start is accepted in IDLE
//   busy, done, fault, data               status and registered load result
//   mem_req/we/addr/be/wdata, mem_ready   request channel to data memory
//   mem_rvalid, mem_rdata                 read-response channel from data memory
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic [31:0] data_q;

  logic        start_fault;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Legality is judged on the raw inputs so a bad access can go straight to DONE.
  // Stores with funct3 1xx are illegal (BU/HU are load-only; 110/111 are illegal anyway).
  always_comb begin
    start_fault = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) start_fault = 1'b1;
    if (is_store && funct3[2])                                     start_fault = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0])                           start_fault = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)                start_fault = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start)      state_d = start_fault ? S_DONE : S_REQ;
      S_REQ:  if (mem_ready)  state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT: if (mem_rvalid) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Lane steering from latched state only, so mem_* never depends combinationally on inputs.
  assign off = addr_q[1:0];

  always_comb begin
    case (f3_q[1:0])
      2'b00:   begin be_c = 4'b0001 << off; wdata_c = {4{wdata_q[7:0]}};  end
      2'b01:   begin be_c = 4'b0011 << off; wdata_c = {2{wdata_q[15:0]}}; end
      default: begin be_c = 4'b1111;        wdata_c = wdata_q;             end
    endcase
  end

  always_comb begin
    case (off)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      fault_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        we_q    <= is_store;
        f3_q    <= funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
        fault_q <= start_fault;
      end
      if (state_q == S_WAIT && mem_rvalid) data_q <= ld_ext;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_DONE) && fault_q;
  assign data      = data_q;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = (state_q == S_REQ) && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = (state_q == S_REQ) ? be_c : 4'b0000;
  assign mem_wdata = wdata_c;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Drives inputs and samples outputs 1 time unit after each rising clock edge.
// Memory handshake signals are driven directly by each scenario task.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault), .data(data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one access, let the edge accept it, then drop start.
  task automatic start_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); is_store = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom; mem_ready = 1'($urandom);
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      tick();
    end
    n_checks++;
    if ({busy, done, fault, mem_req, mem_we, mem_be, data} !== 41'd0)
      $display("FAIL reset_outputs: got busy=%b done=%b fault=%b req=%b we=%b be=%b data=%h, want all 0",
               busy, done, fault, mem_req, mem_we, mem_be, data);
    else n_pass++;

    rst_n = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    start_access(1'b0, 3'b010, 32'h100, 32'h0);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_be !== 4'hF)
      $display("FAIL lw_req: got req=%b we=%b addr=%h be=%b, want 1 0 00000100 1111",
               mem_req, mem_we, mem_addr, mem_be);
    else n_pass++;
    tick();
    n_checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL lw_wait: got req=%b done=%b busy=%b, want 0 0 1", mem_req, done, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || fault !== 1'b0 || data !== 32'hDEADBEEF)
      $display("FAIL lw_done_c3: got done=%b fault=%b data=%h, want 1 0 deadbeef", done, fault, data);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data !== 32'hDEADBEEF)
      $display("FAIL lw_idle: got done=%b busy=%b data=%h, want 0 0 deadbeef", done, busy, data);
    else n_pass++;
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    logic [3:0]  bes  [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80FF1234;
    for (int i = 0; i < 4; i++) begin
      start_access(1'b0, f3s[i], adrs[i], 32'h0);
      n_checks++;
      if (mem_addr !== 32'h100 || mem_be !== bes[i])
        $display("FAIL load_lane[%0d]: got addr=%h be=%b, want 00000100 %b", i, mem_addr, mem_be, bes[i]);
      else n_pass++;
      tick(); tick();
      n_checks++;
      if (done !== 1'b1 || data !== exps[i])
        $display("FAIL load_ext[%0d]: got done=%b data=%h, want 1 %h", i, done, data, exps[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_store_lanes();
    // data holds 0x000080FF from the last load
    mem_ready = 1'b1;
    start_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_be !== 4'b1100 ||
        mem_wdata !== 32'hABCDABCD)
      $display("FAIL sh_req: got req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000200 1100 abcdabcd",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || fault !== 1'b0 || data !== 32'h000080FF)
      $display("FAIL sh_done: got done=%b fault=%b data=%h, want 1 0 000080ff", done, fault, data);
    else n_pass++;
    tick();
    start_access(1'b1, 3'b000, 32'h201, 32'h1234565A);
    n_checks++;
    if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A || mem_we !== 1'b1)
      $display("FAIL sb_req: got be=%b wdata=%h we=%b, want 0010 5a5a5a5a 1", mem_be, mem_wdata, mem_we);
    else n_pass++;
    tick(); tick();
  endtask

  task automatic test_sw_stall();
    mem_ready = 1'b0;
    start_access(1'b1, 3'b010, 32'h300, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'hF ||
          mem_wdata !== 32'h12345678 || done !== 1'b0)
        $display("FAIL sw_stall[%0d]: got req=%b addr=%h be=%b wdata=%h done=%b, want 1 00000300 1111 12345678 0",
                 i, mem_req, mem_addr, mem_be, mem_wdata, done);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    n_checks++;
    if (mem_req !== 1'b1 || done !== 1'b0)
      $display("FAIL sw_c4: got req=%b done=%b, want 1 0", mem_req, done);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1 || fault !== 1'b0)
      $display("FAIL sw_done_c5: got done=%b fault=%b, want 1 0", done, fault);
    else n_pass++;
    tick();
  endtask

  task automatic test_faults();
    logic        sts  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adrs [4] = '{32'h102, 32'h001, 32'h000, 32'h000};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_access(sts[i], f3s[i], adrs[i], 32'hFFFFFFFF);
      n_checks++;
      if (done !== 1'b1 || fault !== 1'b1 || mem_req !== 1'b0 || data !== 32'h000080FF)
        $display("FAIL fault[%0d]: got done=%b fault=%b req=%b data=%h, want 1 1 0 000080ff",
                 i, done, fault, mem_req, data);
      else n_pass++;
      tick();
      n_checks++;
      if (done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL fault_after[%0d]: got done=%b fault=%b busy=%b req=%b, want 0 0 0 0",
                 i, done, fault, busy, mem_req);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h11111111;
    start_access(1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    n_checks++;
    if (busy !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL mid_wait: got busy=%b req=%b, want 1 0", busy, mem_req);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1 || busy !== 1'b0 || data !== 32'd0) ndone++;
      tick();
    end
    n_checks++;
    if (ndone != 0)
      $display("FAIL mid_reset: got %0d bad cycles (busy/done/data nonzero), want 0 (data=%h)", ndone, data);
    else n_pass++;
  endtask

  task automatic test_busy_start();
    int ndone = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    start_access(1'b1, 3'b010, 32'h500, 32'hCAFEF00D);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h600;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'hCAFEF00D)
      $display("FAIL busy_start_req: got req=%b we=%b addr=%h wdata=%h, want 1 1 00000500 cafef00d",
               mem_req, mem_we, mem_addr, mem_wdata);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    if (done === 1'b1) ndone++;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    n_checks++;
    if (ndone != 1 || busy !== 1'b0 || data !== 32'd0)
      $display("FAIL busy_start_done: got %0d done pulses busy=%b data=%h, want 1 0 00000000",
               ndone, busy, data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b1;
    start_access(1'b1, 3'b010, 32'h700, 32'h01010101);
    tick();
    n_checks++;
    if (done !== 1'b1)
      $display("FAIL b2b_done_a: got done=%b, want 1", done);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL b2b_idle: got busy=%b, want 0", busy);
    else n_pass++;
    start_access(1'b1, 3'b010, 32'h704, 32'h02020202);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h704 || mem_wdata !== 32'h02020202)
      $display("FAIL b2b_req_b: got req=%b addr=%h wdata=%h, want 1 00000704 02020202",
               mem_req, mem_addr, mem_wdata);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1)
      $display("FAIL b2b_done_b: got done=%b, want 1", done);
    else n_pass++;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_load_extend();
    test_store_lanes();
    test_sw_stall();
    test_faults();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
